// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter shared types: owner states, requester id, read tags.
// Default widths for the arbiter and its read-return tracker.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  function automatic logic [2:0] burst_inc(
    input logic [2:0] cnt,
    input logic [2:0] lim
  );
    return (cnt >= lim) ? lim : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/rd_tracker.sv
// Read-return tracker: RD_LAT-deep {valid, id} delay line.
// Steers the RAM read data to the requester whose read is due.
module rd_tracker
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  req_id_t           push_id,
  input  logic [DATA_W-1:0] mem_q,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata
);

  rd_tag_t pipe [RD_LAT];
  rd_tag_t tail;

  // delay each read grant by the RAM latency; reset drops reads in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= rd_tag_t'{valid: push, id: push_id};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail    = pipe[RD_LAT-1];
  assign rvalid0 = tail.valid && (tail.id == 1'b0);
  assign rvalid1 = tail.valid && (tail.id == 1'b1);
  assign rdata   = tail.valid ? mem_q : '0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester RAM port arbiter with lock/burst ownership.
// MEM_ARB_FIXED_PRI_EN: idle ties always go to requester 0.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [2:0] MAX_B = 3'(MAX_BURST);

  state_t     state;
  logic [2:0] burst;
  logic       cap;
  logic       tie0;
  logic       win0;
  logic       win1;
  logic       rd_push;

`ifdef MEM_ARB_FIXED_PRI_EN
  assign tie0 = 1'b1;
`else
  req_id_t last_gnt;

  // remember the most recent winner so ties rotate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= 1'b1;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end

  assign tie0 = last_gnt;
`endif

  assign cap = (burst >= MAX_B);

  // owner wins unless its burst is spent and the other side waits
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    unique case (1'b1)
      state == OWN0: begin
        if (req0 && !(cap && req1)) win0 = 1'b1;
        else                        win1 = req1;
      end
      state == OWN1: begin
        if (req1 && !(cap && req0)) win1 = 1'b1;
        else                        win0 = req0;
      end
      default: begin
        if (req0 && req1) begin
          win0 = tie0;
          win1 = !tie0;
        end else begin
          win0 = req0;
          win1 = req1;
        end
      end
    endcase
  end

  assign gnt0 = win0 & reset;
  assign gnt1 = win1 & reset;

  assign mem_wren    = (gnt0 & we0) | (gnt1 & we1);
  assign mem_address = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
  assign mem_data    = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);
  assign rd_push     = (gnt0 & ~we0) | (gnt1 & ~we1);

  // ownership: enter on a locked grant, leave on any other outcome
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      burst <= '0;
    end else begin
      unique case (state)
        OWN0: begin
          if (gnt0 && lock0) begin
            burst <= burst_inc(burst, MAX_B);
          end else begin
            state <= IDLE;
            burst <= '0;
          end
        end
        OWN1: begin
          if (gnt1 && lock1) begin
            burst <= burst_inc(burst, MAX_B);
          end else begin
            state <= IDLE;
            burst <= '0;
          end
        end
        default: begin
          if (gnt0 && lock0) begin
            state <= OWN0;
            burst <= 3'd1;
          end else if (gnt1 && lock1) begin
            state <= OWN1;
            burst <= 3'd1;
          end else begin
            state <= IDLE;
            burst <= '0;
          end
        end
      endcase
    end
  end

  rd_tracker #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_rd_tracker (
    .clk     (clk),
    .reset   (reset),
    .push    (rd_push),
    .push_id (gnt1),
    .mem_q   (mem_q),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata   (rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a rule-level model with a RAM and read-return queue.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 1;
  localparam int MB  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0 = 0, req1 = 0, lock0 = 0, lock1 = 0;
  logic          we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_wren;
  logic [DW-1:0] rdata, mem_data, mem_q;
  logic [AW-1:0] mem_address;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  logic [DW-1:0] ram [2**AW];
  logic [DW-1:0] qp [LAT];

  always @(posedge clk) begin
    if (mem_wren) ram[mem_address] <= mem_data;
    qp[0] <= ram[mem_address];
    for (int i = 1; i < LAT; i++) qp[i] <= qp[i-1];
  end
  assign mem_q = qp[LAT-1];

  assert property (@(posedge clk) !(gnt0 && gnt1));
  assert property (@(posedge clk) mem_wren |-> (gnt0 || gnt1));

  typedef struct {
    int            due;
    int            id;
    logic [DW-1:0] data;
  } rt_t;

  logic [DW-1:0] shadow [2**AW];
  rt_t           rq [$];
  int            glog [$];
  int owner = -1, cnt = 0, last = 1, cyc = 0, ew = -1;
  int n_cmp = 0, n_bad = 0, rd_grants = 0, rv_seen = 0;
  logic          s_rv0, s_rv1, s_wren;
  logic [DW-1:0] s_rdata;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_win();
    int o, p;
    logic r [2];
    r[0] = req0;
    r[1] = req1;
    if (owner >= 0) begin
      o = owner;
      p = 1 - owner;
      if (r[o] && !(cnt >= MB && r[p])) return o;
      return r[p] ? p : -1;
    end
    if (r[0] && r[1]) begin
`ifdef MEM_ARB_FIXED_PRI_EN
      return 0;
`else
      return 1 - last;
`endif
    end
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  task automatic step();
    logic          w, lk, e0, e1;
    logic [AW-1:0] a;
    logic [DW-1:0] d, ed;
    @(negedge clk);
    ew = model_win();
    w  = (ew == 1) ? we1 : we0;
    lk = (ew == 1) ? lock1 : lock0;
    a  = (ew == 1) ? addr1 : addr0;
    d  = (ew == 1) ? wdata1 : wdata0;
    chk("gnt0", 32'(gnt0), 32'(ew == 0));
    chk("gnt1", 32'(gnt1), 32'(ew == 1));
    chk("wren", 32'(mem_wren), 32'(ew >= 0 && w));
    chk("maddr", 32'(mem_address), (ew >= 0) ? 32'(a) : 32'd0);
    chk("mdata", 32'(mem_data), (ew >= 0) ? 32'(d) : 32'd0);
    e0 = 0;
    e1 = 0;
    ed = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e0 = (rq[0].id == 0);
      e1 = (rq[0].id == 1);
      ed = rq[0].data;
      void'(rq.pop_front());
    end
    chk("rvalid0", 32'(rvalid0), 32'(e0));
    chk("rvalid1", 32'(rvalid1), 32'(e1));
    chk("rdata", 32'(rdata), 32'(ed));
    s_rv0   = rvalid0;
    s_rv1   = rvalid1;
    s_rdata = rdata;
    s_wren  = mem_wren;
    rv_seen += int'(rvalid0) + int'(rvalid1);
    if (ew >= 0) begin
      if (w) begin
        shadow[a] = d;
      end else begin
        rq.push_back('{due: cyc + LAT, id: ew, data: shadow[a]});
        rd_grants++;
      end
      last = ew;
    end
    if (owner < 0) begin
      if (ew >= 0 && lk) begin
        owner = ew;
        cnt   = 1;
      end
    end else if (ew == owner && lk) begin
      cnt = (cnt >= MB) ? MB : cnt + 1;
    end else begin
      owner = -1;
      cnt   = 0;
    end
    glog.push_back(ew);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_ctl", 32'({gnt0, gnt1, rvalid0, rvalid1, mem_wren}), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
    end
    rd_grants -= rq.size();
    rq.delete();
    owner = -1;
    cnt   = 0;
    last  = 1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle_in();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
  endtask

  int exp19 [4];
  int exp20 [5];
  logic p0, p1;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    ram[16'h0010]    = 16'hBEEF;
    shadow[16'h0010] = 16'hBEEF;
    apply_reset(3);

    // single read
    req0 = 1; addr0 = 16'h0010;
    step();
    chk("t18_gnt0", 32'(glog[$]), 32'd0);
    idle_in();
    step();
    chk("t18_rv0", 32'(s_rv0), 32'd1);
    chk("t18_rdata", 32'(s_rdata), 32'hBEEF);

    // tie round-robin
    apply_reset(1);
    glog.delete();
`ifdef MEM_ARB_FIXED_PRI_EN
    exp19 = '{0, 0, 0, 0};
`else
    exp19 = '{0, 1, 0, 1};
`endif
    req0 = 1; req1 = 1; addr0 = 16'h0001; addr1 = 16'h0002;
    repeat (4) step();
    for (int i = 0; i < 4; i++) chk($sformatf("t19_g%0d", i), 32'(glog[i]), 32'(exp19[i]));
    idle_in();
    repeat (2) step();

    // locked burst then preemption, then saturation
    apply_reset(1);
    glog.delete();
    exp20 = '{0, 0, 0, 0, 1};
    req0 = 1; lock0 = 1; req1 = 1;
    repeat (5) step();
    for (int i = 0; i < 5; i++) chk($sformatf("t20_g%0d", i), 32'(glog[i]), 32'(exp20[i]));
    req1 = 0;
    glog.delete();
    repeat (6) step();
    for (int i = 0; i < 6; i++) chk($sformatf("t20_own%0d", i), 32'(glog[i]), 32'd0);
    req1 = 1;
    step();
    chk("t20_sat", 32'(glog[$]), 32'd1);
    idle_in();
    repeat (2) step();

    // write then read back
    req1 = 1; we1 = 1; addr1 = 16'h0020; wdata1 = 16'h1234;
    step();
    chk("t21_wren", 32'(s_wren), 32'd1);
    we1 = 0;
    step();
    chk("t21_nowr", 32'(s_rv0 | s_rv1 | s_wren), 32'd0);
    idle_in();
    step();
    chk("t21_rv1", 32'(s_rv1), 32'd1);
    chk("t21_rdata", 32'(s_rdata), 32'h1234);

    // reset while a read is in flight
    req0 = 1; addr0 = 16'h0010;
    step();
    idle_in();
    apply_reset(2);
    step();
    chk("t22_norv", 32'(s_rv0 | s_rv1), 32'd0);
    req0 = 1; req1 = 1;
    step();
    chk("t22_tie", 32'(glog[$]), 32'd0);
    idle_in();
    repeat (2) step();

    // random traffic; a requester holds its request until granted
    p0 = 0;
    p1 = 0;
    repeat (600) begin
      if (!p0 || ew == 0) begin
        p0 = ($urandom_range(3) != 0);
        req0 = p0; we0 = 1'($urandom_range(1));
        addr0 = 16'($urandom_range(31)); wdata0 = 16'($urandom);
      end
      if (!p1 || ew == 1) begin
        p1 = ($urandom_range(3) != 0);
        req1 = p1; we1 = 1'($urandom_range(1));
        addr1 = 16'($urandom_range(31)); wdata1 = 16'($urandom);
      end
      lock0 = 1'($urandom_range(1));
      lock1 = 1'($urandom_range(1));
      step();
    end
    idle_in();
    repeat (LAT + 2) step();
    chk("rv_count", 32'(rv_seen), 32'(rd_grants));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_W, 16, memory address width
  DATA_W, 16, memory data width
  RD_LAT, 1, RAM read latency in cycles (legal 1..2)
  MAX_BURST, 4, maximum consecutive grants to one locked owner
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state on rising edge
  reset  in  1  asynchronous, active-low reset
  req0/req1  in  1  access request, requester 0/1
  lock0/lock1  in  1  requester asks to keep ownership for next access
  we0/we1  in  1  1=write, 0=read
  addr0/addr1  in  ADDR_W  request address
  wdata0/wdata1  in  DATA_W  write data
  gnt0/gnt1  out  1  access issued to RAM this cycle
  rvalid0/rvalid1  out  1  read data valid
  rdata  out  DATA_W  read data, shared
  mem_address  out  ADDR_W  to RAM port B address
  mem_data  out  DATA_W  to RAM port B write data
  mem_wren  out  1  to RAM port B write enable
  mem_q  in  DATA_W  from RAM port B read data

Function
REQ-003 SHALL issue at most one RAM access per cycle; gnt0 and gnt1 SHALL never be high together.
REQ-004 Requester SHALL hold req/we/addr/wdata stable until its gnt; gnt is a 1-cycle-per-access acknowledge; req held high after gnt = new access.
REQ-005 In a gnt cycle, mem_address/mem_data/mem_wren SHALL reflect the granted requester's inputs combinationally; mem_wren=0, mem_address/mem_data=0 when no gnt.
REQ-006 Read granted in cycle N SHALL produce rvalidX=1 and rdata=mem_q in cycle N+RD_LAT, for one cycle; tracked by an RD_LAT-deep shift register of {valid, id}.
REQ-007 Back-to-back reads SHALL be supported every cycle; rvalid order equals grant order.
REQ-008 FSM states IDLE, OWN0, OWN1; IDLE->OWNx on grant to x with lockx=1; OWNx->IDLE when lockx=0 at a grant, reqx=0, or burst counter reaches MAX_BURST while other req is high.
REQ-009 In OWNx, requester x SHALL win regardless of the other req; burst counter (3 bits) increments per grant, clears on entry to IDLE.
REQ-010 In IDLE, single requester wins; both requesting -> round-robin: winner is the requester not granted last (last_gnt register).
REQ-011 MAX_BURST reached with other req low: SHALL stay in OWNx, counter saturates at MAX_BURST.
REQ-012 Write grant SHALL NOT produce rvalid.

Reset
REQ-013 On reset low: state=IDLE, burst counter=0, last_gnt=1 (requester 0 wins first tie), read pipeline cleared; gnt0/gnt1/rvalid0/rvalid1/mem_wren=0, rdata=0.
REQ-014 Reads in flight at reset SHALL be discarded; no rvalid after release until a new read grant.

Configuration
REQ-015 Macro MEM_ARB_FIXED_PRI_EN: defined -> IDLE ties always go to requester 0, last_gnt unused; undefined -> round-robin per REQ-010. Lock/burst behaviour identical in both.

Structure
REQ-016 Shared package SHALL hold state enum (IDLE/OWN0/OWN1), requester-id type, default ADDR_W/DATA_W.
REQ-017 Sub-module rd_tracker SHALL implement the RD_LAT read-return shift register; rest flat.

Verification
REQ-018 Single read: req0=1, we0=0, addr0=0x0010, RAM holds 0xBEEF -> gnt0 cycle N, rvalid0=1 rdata=0xBEEF at N+RD_LAT.
REQ-019 Tie: req0=req1=1 unlocked, 4 cycles -> grants 0,1,0,1; with MEM_ARB_FIXED_PRI_EN -> 0,0,0,0.
REQ-020 Burst: lock0=1 req0 held, req1=1 -> four gnt0 (MAX_BURST=4), then gnt1; with req1=0 gnt0 continues every cycle.
REQ-021 Write then read: req1 we1=1 addr1=0x0020 wdata1=0x1234, then read 0x0020 -> mem_wren=1 one cycle, rvalid1 rdata=0x1234, no rvalid for write.
REQ-022 Reset mid-read: read granted, reset low before return -> no rvalid, outputs 0, next tie goes to requester 0.
REQ-023 Assertions throughout: never gnt0&gnt1; mem_wren only with gnt; rvalid count equals read-grant count.
